relu_quant_pipe: RTL and testbench

- Streaming, multi-lane post-MACC activation/requantisation unit: ReLU -> full-width right shift (optional rounding) -> optional clip to a programmable ceiling -> saturate to signed OUT_W.
- Parametrised successor of the combinational ReLU output stage. Sits between the MACC accumulator array and the output feature-map buffer.
- 2-stage pipeline with valid/ready backpressure and a saturation-event counter.

---
 rtl/relu_quant_pkg.sv | 34 +++
 rtl/relu_quant_lane.sv | 77 +++++++
 rtl/relu_quant_pipe.sv | 112 +++++++++++
 tb/tb_relu_quant_pipe.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/relu_quant_pkg.sv
// Shared definitions for the ReLU/requantisation datapath and the pooling block that will reuse them.
// Default widths, output-range helpers, the lane slice helper and the packed per-beat lane config.
package relu_quant_pkg;

  localparam int LANES_DEF  = 4;
  localparam int IN_W_DEF   = 16;
  localparam int OUT_W_DEF  = 8;
  localparam int SHFT_W_DEF = 4;
  localparam int CNT_W_DEF  = 16;

  function automatic int out_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int out_min(input int w);
    return -(1 << (w - 1));
  endfunction

  localparam int OUT_MAX = out_max(OUT_W_DEF);
  localparam int OUT_MIN = out_min(OUT_W_DEF);

  // LSB position of lane i in a packed multi-lane vector
  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

  typedef struct packed {
    logic                         shft_flag;
    logic [SHFT_W_DEF-1:0]        shft_val;
    logic                         cmp_flag;
    logic signed [OUT_W_DEF-1:0]  cmp_val;
  } lane_cfg_t;

endpackage

// File: rtl/relu_quant_lane.sv
// Single-lane combinational datapath: stage 1 (ReLU + shift) and stage 2 (clip + saturate + event).
// Build option: RELU_QUANT_ROUND_EN selects round-half-up shifting instead of truncation.
module relu_quant_lane
  import relu_quant_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int SHFT_W = SHFT_W_DEF
) (
  input  logic signed [IN_W-1:0]   x,
  input  logic                     shft_flag,
  input  logic        [SHFT_W-1:0] shft_val,
  output logic        [IN_W-1:0]   s,
  input  logic        [IN_W-1:0]   s_q,
  input  logic                     cmp_flag,
  input  logic signed [OUT_W-1:0]  cmp_val,
  output logic signed [OUT_W-1:0]  y,
  output logic                     evt
);

  localparam logic [IN_W-1:0] OUT_MAX_EXT = IN_W'(out_max(OUT_W));

  logic [IN_W-1:0] r;
  logic [IN_W-1:0] cmp_ext;
  logic [IN_W-1:0] y_w;
  logic            clip;
  logic            sat;

  always_comb r = x[IN_W-1] ? '0 : x;

`ifdef RELU_QUANT_ROUND_EN
  logic [IN_W:0] rnd_bit;
  logic [IN_W:0] rnd_sum;

  // One extra bit keeps the rounding carry; the result is always narrower after the shift
  always_comb begin
    rnd_bit = '0;
    rnd_sum = '0;
    s       = r;
    if (shft_flag) begin
      if (shft_val != '0) begin
        rnd_bit = (IN_W+1)'(1) << (shft_val - 1'b1);
        rnd_sum = {1'b0, r} + rnd_bit;
        s       = IN_W'(rnd_sum >> shft_val);
      end
    end
  end
`else
  always_comb s = shft_flag ? (r >> shft_val) : r;
`endif

  // s_q is never negative, so comparisons are done unsigned at IN_W
  always_comb begin
    cmp_ext = IN_W'(unsigned'(cmp_val));
    y_w     = s_q;
    clip    = 1'b0;
    sat     = 1'b0;
    if (cmp_flag) begin
      if (!cmp_val[OUT_W-1]) begin
        if (s_q > cmp_ext) begin
          y_w  = cmp_ext;
          clip = 1'b1;
        end
      end else begin
        y_w  = '0;
        clip = (s_q != '0);
      end
    end
    if (y_w > OUT_MAX_EXT) begin
      y_w = OUT_MAX_EXT;
      sat = 1'b1;
    end
    y   = y_w[OUT_W-1:0];
    evt = clip | sat;
  end

endmodule

// File: rtl/relu_quant_pipe.sv
// Multi-lane ReLU -> shift -> clip -> saturate unit, 2-stage valid/ready pipeline with saturation counter.
// Build option: RELU_QUANT_ROUND_EN (rounding shift inside relu_quant_lane).
module relu_quant_pipe
  import relu_quant_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int IN_W   = IN_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int SHFT_W = SHFT_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*IN_W-1:0]    in_data,
  input  logic                     shft_flag,
  input  logic [SHFT_W-1:0]        shft_val,
  input  logic                     cmp_flag,
  input  logic signed [OUT_W-1:0]  cmp_val,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*OUT_W-1:0]   out_data,
  input  logic                     sat_clr,
  output logic [CNT_W-1:0]         sat_cnt
);

  localparam int EVT_W = $clog2(LANES + 1);

  logic                     s1_valid;
  logic                     s2_valid;
  logic                     s1_advance;
  logic [LANES*IN_W-1:0]    s1_s;
  logic                     s1_cmp_flag;
  logic signed [OUT_W-1:0]  s1_cmp_val;

  logic [LANES*IN_W-1:0]    s_nxt;
  logic [LANES*OUT_W-1:0]   y_nxt;
  logic [LANES-1:0]         evt;
  logic [EVT_W-1:0]         n_evt;
  logic [CNT_W:0]           cnt_sum;

  assign s1_advance = ~s2_valid | out_ready;
  assign in_ready   = ~s1_valid | s1_advance;
  assign out_valid  = s2_valid;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    relu_quant_lane #(
      .IN_W   (IN_W),
      .OUT_W  (OUT_W),
      .SHFT_W (SHFT_W)
    ) u_lane (
      .x         (in_data[lane_lsb(i, IN_W) +: IN_W]),
      .shft_flag (shft_flag),
      .shft_val  (shft_val),
      .s         (s_nxt[lane_lsb(i, IN_W) +: IN_W]),
      .s_q       (s1_s[lane_lsb(i, IN_W) +: IN_W]),
      .cmp_flag  (s1_cmp_flag),
      .cmp_val   (s1_cmp_val),
      .y         (y_nxt[lane_lsb(i, OUT_W) +: OUT_W]),
      .evt       (evt[i])
    );
  end

  always_comb begin
    n_evt = '0;
    for (int i = 0; i < LANES; i++) begin
      n_evt = n_evt + EVT_W'(evt[i]);
    end
    cnt_sum = {1'b0, sat_cnt} + (CNT_W+1)'(n_evt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_s        <= '0;
      s1_cmp_flag <= 1'b0;
      s1_cmp_val  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_s        <= s_nxt;
        s1_cmp_flag <= cmp_flag;
        s1_cmp_val  <= cmp_val;
      end
    end
  end

  // out_data only moves on a stage-2 load, which keeps it stable through a stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_data <= '0;
    end else if (s1_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= y_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (sat_clr) begin
      sat_cnt <= '0;
    end else if (s1_advance && s1_valid) begin
      sat_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_relu_quant_pipe.sv
// Randomised and directed bench for relu_quant_pipe against an arithmetic reference model.
// Honours RELU_QUANT_ROUND_EN for the expected shift behaviour.
module tb_relu_quant_pipe;

  localparam int LANES  = 4;
  localparam int IN_W   = 16;
  localparam int OUT_W  = 8;
  localparam int SHFT_W = 4;
  localparam int CNT_W  = 16;
  localparam int CNT_MAX = 65535;

`ifdef RELU_QUANT_ROUND_EN
  localparam int EXP_1004 = 126;
`else
  localparam int EXP_1004 = 125;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*IN_W-1:0]   in_data;
  logic                    shft_flag;
  logic [SHFT_W-1:0]       shft_val;
  logic                    cmp_flag;
  logic signed [OUT_W-1:0] cmp_val;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*OUT_W-1:0]  out_data;
  logic                    sat_clr;
  logic [CNT_W-1:0]        sat_cnt;

  relu_quant_pipe #(
    .LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .SHFT_W(SHFT_W), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .shft_flag (shft_flag),
    .shft_val  (shft_val),
    .cmp_flag  (cmp_flag),
    .cmp_val   (cmp_val),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sat_clr   (sat_clr),
    .sat_cnt   (sat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    bit          sf;
    logic [3:0]  sv;
    bit          cf;
    logic [7:0]  cv;
  } beat_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          exp_sat = 0;
  int          occ = 0;
  int          ret_cnt = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_data;
  int          rdy_mode = 0;
  bit          rdy_fixed = 1;
  bit          pat[5] = '{1, 0, 0, 1, 1};

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on one lane
  function automatic int ref_lane(input int x, input bit sf, input int sv, input bit cf,
                                  input int cv, output bit ev);
    int r, s, y;
    r = (x < 0) ? 0 : x;
    s = r;
    if (sf) begin
`ifdef RELU_QUANT_ROUND_EN
      if (sv > 0) s = (r + (1 << sv) / 2) / (1 << sv);
`else
      s = r / (1 << sv);
`endif
    end
    y  = s;
    ev = 0;
    if (cf) begin
      if (cv >= 0) begin
        if (s > cv) begin y = cv; ev = 1; end
      end else begin
        y  = 0;
        ev = (s > 0);
      end
    end
    if (y > 127) begin y = 127; ev = 1; end
    return y;
  endfunction

  function automatic void model_push(input beat_t b);
    logic [31:0] y;
    int n, v;
    bit ev;
    y = '0;
    n = 0;
    for (int i = 0; i < LANES; i++) begin
      v = ref_lane(int'($signed(b.d[i*16 +: 16])), b.sf, int'(b.sv), b.cf, int'($signed(b.cv)), ev);
      y[i*8 +: 8] = 8'(v);
      n += int'(ev);
    end
    exp_q.push_back(y);
    exp_sat = (exp_sat + n > CNT_MAX) ? CNT_MAX : exp_sat + n;
  endfunction

  function automatic beat_t mk(input int l0, input int l1, input int l2, input int l3,
                               input bit sf, input int sv, input bit cf, input int cv);
    beat_t b;
    b.d  = {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
    b.sf = sf;
    b.sv = 4'(sv);
    b.cf = cf;
    b.cv = 8'(cv);
    return b;
  endfunction

  function automatic int rand_lane();
    case ($urandom_range(0, 3))
      0:       return int'($signed(16'($urandom)));
      1:       return int'($urandom_range(0, 600)) - 200;
      2:       return int'($urandom_range(0, 255));
      default: return int'($urandom_range(0, 32767));
    endcase
  endfunction

  // Call at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send_beat(input beat_t b);
    bit acc;
    int n;
    in_valid  = 1'b1;
    in_data   = b.d;
    shft_flag = b.sf;
    shft_val  = b.sv;
    cmp_flag  = b.cf;
    cmp_val   = b.cv;
    acc = 0;
    n   = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) model_push(b);
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check_val("accept_timeout", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic one_shot(input beat_t b, output logic [31:0] res);
    send_beat(b);
    res = 'x;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (out_valid) begin
        res = out_data;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    rdy_mode  = 0;
    rdy_fixed = 1;
    n = 0;
    while ((exp_q.size() != 0 || occ != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check_val("drain_empty", exp_q.size(), 0);
  endtask

  task automatic clear_sat();
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    exp_sat = 0;
    check_val("sat_clear", sat_cnt, 0);
  endtask

  // out_ready driver: fixed, 1-0-0-1-1 pattern, or random
  initial begin
    int pi;
    pi = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       begin out_ready = pat[pi]; pi = (pi + 1) % 5; end
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = rdy_fixed;
      endcase
    end
  end

  // Scoreboard, stall-stability and in_ready checks
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        occ        = 0;
        prev_stall = 0;
      end else begin
        check_val("in_ready", in_ready, !(occ == 2 && !out_ready));
        if (prev_stall) begin
          check_val("hold_valid", out_valid, 1);
          check_val("hold_data", out_data, prev_data);
        end
        if (out_valid && out_ready) begin
          ret_cnt++;
          if (exp_q.size() == 0) check_val("extra_beat", exp_q.size(), 1);
          else check_val("out_data", out_data, exp_q.pop_front());
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        occ += int'(in_valid && in_ready) - int'(out_valid && out_ready);
      end
    end
  end

  initial begin
    logic [31:0] res;
    int base;
    beat_t b;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    shft_flag = 1'b0;
    shft_val  = '0;
    cmp_flag  = 1'b0;
    cmp_val   = '0;
    sat_clr   = 1'b0;

    repeat (3) @(negedge clk);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_sat_cnt", sat_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // latency and basic ReLU/saturation
    send_beat(mk(-5, 300, 127, 0, 0, 0, 0, 0));
    @(negedge clk);
    check_val("lat_early", out_valid, 0);
    @(negedge clk);
    check_val("lat_valid", out_valid, 1);
    check_val("lat_data", out_data, 32'h007F_7F00);
    drain();
    check_val("sat_first", sat_cnt, 1);

    // shift, with and without rounding
    one_shot(mk(1000, 1004, -7, 7, 1, 3, 0, 0), res);
    check_val("shift_1000", res[7:0], 125);
    check_val("shift_1004", res[15:8], EXP_1004);
    check_val("shift_neg", res[23:16], 0);

    // clip
    clear_sat();
    one_shot(mk(100, 40, 10, 0, 0, 0, 1, 50), res);
    check_val("clip_100", res[7:0], 50);
    check_val("clip_40", res[15:8], 40);
    one_shot(mk(10, 0, -4, 0, 0, 0, 1, -3), res);
    check_val("clip_neg", res[7:0], 0);
    drain();
    check_val("clip_events", sat_cnt, 2);

    // 10-beat stream under 1,0,0,1,1 backpressure
    clear_sat();
    base = ret_cnt;
    rdy_mode = 1;
    for (int i = 0; i < 10; i++) begin
      send_beat(mk(rand_lane(), rand_lane(), rand_lane(), rand_lane(),
                   i[0], i % 5, i[1], 60 - 10 * i));
    end
    drain();
    check_val("pattern_count", ret_cnt - base, 10);
    check_val("pattern_sat", sat_cnt, exp_sat);

    // random stream with random backpressure and gaps
    clear_sat();
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      b = mk(rand_lane(), rand_lane(), rand_lane(), rand_lane(),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 255)) - 128);
      send_beat(b);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
    drain();
    check_val("random_sat", sat_cnt, exp_sat);

    // counter saturation
    clear_sat();
    for (int i = 0; i < 16400; i++) send_beat(mk(1000, 1000, 1000, 1000, 0, 0, 0, 0));
    drain();
    check_val("sat_hold_max", sat_cnt, CNT_MAX);
    check_val("sat_model_max", exp_sat, CNT_MAX);

    // clear while increments are landing
    clear_sat();
    fork
      for (int i = 0; i < 10; i++) send_beat(mk(500, 500, 0, 0, 0, 0, 0, 0));
      begin
        repeat (5) @(posedge clk);
        #1;
        sat_clr = 1'b1;
        @(negedge clk);
        check_val("clr_busy_pre", sat_cnt != 0, 1);
        @(negedge clk);
        check_val("clr_wins", sat_cnt, 0);
        sat_clr = 1'b0;
      end
    join
    drain();
    clear_sat();

    // reset with two beats in flight
    rdy_fixed = 0;
    repeat (2) begin @(posedge clk); #1; end
    send_beat(mk(300, 300, 300, 300, 0, 0, 0, 0));
    send_beat(mk(400, 400, 400, 400, 0, 0, 0, 0));
    check_val("pre_rst_valid", out_valid, 1);
    check_val("pre_rst_sat", sat_cnt, 4);
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_valid", out_valid, 0);
    check_val("rst_mid_data", out_data, 0);
    check_val("rst_mid_sat", sat_cnt, 0);
    exp_q.delete();
    exp_sat = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rdy_fixed = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("no_stale", out_valid, 0);
    end
    check_val("final_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
